// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: two-axis fixed-point motion controller for a keyboard
// driven sprite, with playfield clamping and a collision-triggered stun.
//
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   startOfFrame       one-clk pulse per frame; all motion updates happen here
//   enable             0 freezes state, counter, speeds and position
//   right/left/up/downPress  held keys
//   collision          level, sprite overlaps a hazard
//   topLeftX/Y         pixel position (floor of fixed-point position)
//   speedX/Y           current per-axis speed register (fixed-point)
//   stunned            1 while frozen after a collision
//
// Build option: define SPRITE_MOTION_WRAP_EN to make the X axis wrap around
// the playfield instead of clamping (speedX is kept on wrap).
module sprite_motion_ctrl #(
   parameter int FRAC_BITS   = 6,
   parameter int INITIAL_X   = 320,
   parameter int INITIAL_Y   = 300,
   parameter int OBJ_W       = 64,
   parameter int OBJ_H       = 32,
   parameter int MIN_X       = 10,
   parameter int MAX_X       = 630,
   parameter int MIN_Y       = 0,
   parameter int MAX_Y       = 479,
   parameter int MAX_SPEED   = 120,
   parameter int ACCEL       = 20,
   parameter int STUN_FRAMES = 15
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic               rightPress,
   input  logic               leftPress,
   input  logic               upPress,
   input  logic               downPress,
   input  logic               collision,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic signed [11:0] speedX,
   output logic signed [11:0] speedY,
   output logic               stunned
);

   localparam int ONE = 1 << FRAC_BITS;
   localparam int CW  = (STUN_FRAMES > 0) ? $clog2(STUN_FRAMES + 1) : 1;

   localparam logic signed [31:0] MAX_S  = 32'(MAX_SPEED);
   localparam logic signed [31:0] ACC_S  = 32'(ACCEL);
   localparam logic signed [31:0] INIT_X = 32'(INITIAL_X * ONE);
   localparam logic signed [31:0] INIT_Y = 32'(INITIAL_Y * ONE);
   localparam logic signed [31:0] Y_LO   = 32'(MIN_Y * ONE);
   localparam logic signed [31:0] Y_HI   = 32'((MAX_Y - OBJ_H) * ONE);
`ifdef SPRITE_MOTION_WRAP_EN
   localparam logic signed [31:0] XW_HI  = 32'(MAX_X * ONE);
   localparam logic signed [31:0] XW_LO  = 32'((MIN_X - OBJ_W) * ONE);
`else
   localparam logic signed [31:0] X_LO   = 32'(MIN_X * ONE);
   localparam logic signed [31:0] X_HI   = 32'((MAX_X - OBJ_W) * ONE);
`endif

   typedef enum logic {RUN, STUN} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic                 coll_latch;
   logic signed [31:0]   posX;
   logic signed [31:0]   posY;

   logic signed [31:0]   sx;
   logic signed [31:0]   sy;
   logic signed [31:0]   sum_x;
   logic signed [31:0]   sum_y;
   logic signed [31:0]   nx_px;
   logic signed [31:0]   nx_py;
   logic signed [11:0]   nx_vx;
   logic signed [11:0]   nx_vy;
   logic                 hit;

   // One-frame speed step: accelerate toward the held direction, or bleed
   // toward zero without overshoot when no single key is held.
   function automatic logic signed [11:0] step_speed(
      input logic signed [31:0] s,
      input logic               pos,
      input logic               neg
   );
      logic signed [31:0] r;
      r = s;
      priority case (1'b1)
         (pos && !neg): r = (s + ACC_S > MAX_S) ? MAX_S : s + ACC_S;
         (neg && !pos): r = (s - ACC_S < -MAX_S) ? -MAX_S : s - ACC_S;
         (s > 0):       r = (s > ACC_S) ? s - ACC_S : '0;
         (s < 0):       r = (s < -ACC_S) ? s + ACC_S : '0;
         default:       r = s;
      endcase
      return 12'(r);
   endfunction

   always_comb begin
      sx    = {{20{speedX[11]}}, speedX};
      sy    = {{20{speedY[11]}}, speedY};
      sum_x = posX + sx;
      sum_y = posY + sy;
      nx_px = sum_x;
      nx_py = sum_y;
      nx_vx = step_speed(sx, rightPress, leftPress);
      nx_vy = step_speed(sy, downPress, upPress);
`ifdef SPRITE_MOTION_WRAP_EN
      if (sum_x > XW_HI)
         nx_px = XW_LO;
      else if (sum_x < XW_LO)
         nx_px = XW_HI;
`else
      if (sum_x < X_LO) begin
         nx_px = X_LO;
         nx_vx = '0;
      end else if (sum_x > X_HI) begin
         nx_px = X_HI;
         nx_vx = '0;
      end
`endif
      if (sum_y < Y_LO) begin
         nx_py = Y_LO;
         nx_vy = '0;
      end else if (sum_y > Y_HI) begin
         nx_py = Y_HI;
         nx_vy = '0;
      end
      // A collision on the frame pulse itself counts for this frame.
      hit = coll_latch | collision;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= RUN;
         cnt        <= '0;
         coll_latch <= 1'b0;
         posX       <= INIT_X;
         posY       <= INIT_Y;
         speedX     <= '0;
         speedY     <= '0;
         stunned    <= 1'b0;
      end else begin
         if (startOfFrame)
            coll_latch <= 1'b0;
         else if (collision)
            coll_latch <= 1'b1;

         if (startOfFrame && enable) begin
            unique case (state)
               RUN: begin
                  posX <= nx_px;
                  posY <= nx_py;
                  if (hit) begin
                     state   <= STUN;
                     cnt     <= CW'(STUN_FRAMES);
                     speedX  <= '0;
                     speedY  <= '0;
                     stunned <= 1'b1;
                  end else begin
                     speedX  <= nx_vx;
                     speedY  <= nx_vy;
                  end
               end
               STUN: begin
                  // Counter of 0 (STUN_FRAMES=0) still costs one frame.
                  if (cnt <= CW'(1)) begin
                     state   <= RUN;
                     cnt     <= '0;
                     stunned <= 1'b0;
                  end else begin
                     cnt     <= cnt - CW'(1);
                  end
               end
            endcase
         end
      end
   end

   assign topLeftX = 11'(posX >>> FRAC_BITS);
   assign topLeftY = 11'(posY >>> FRAC_BITS);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed scenarios plus randomized frames checked
// against a frame-level arithmetic model of the sprite.
module tb_sprite_motion_ctrl;

   localparam int U     = 64;
   localparam int MAXS  = 120;
   localparam int ACC   = 20;
   localparam int NSTUN = 15;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic               enable;
   logic               rightPress;
   logic               leftPress;
   logic               upPress;
   logic               downPress;
   logic               collision;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic signed [11:0] speedX;
   logic signed [11:0] speedY;
   logic               stunned;

   always #5 clk = ~clk;

   sprite_motion_ctrl dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .enable       (enable),
      .rightPress   (rightPress),
      .leftPress    (leftPress),
      .upPress      (upPress),
      .downPress    (downPress),
      .collision    (collision),
      .topLeftX     (topLeftX),
      .topLeftY     (topLeftY),
      .speedX       (speedX),
      .speedY       (speedY),
      .stunned      (stunned)
   );

   int m_px, m_py, m_vx, m_vy, m_left;
   bit m_stun, m_latch;
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp)
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic int toward(input int v, input int t);
      if (v < t) return (v + ACC > t) ? t : v + ACC;
      if (v > t) return (v - ACC < t) ? t : v - ACC;
      return v;
   endfunction

   task automatic model_reset();
      m_px = 320 * U; m_py = 300 * U;
      m_vx = 0; m_vy = 0;
      m_stun = 0; m_latch = 0; m_left = 0;
   endtask

   task automatic model_frame(input bit r, l, u, d, en, coll);
      bit h;
      h = m_latch | coll;
      m_latch = 0;
      if (!en) return;
      if (m_stun) begin
         m_left--;
         if (m_left <= 0) m_stun = 0;
         return;
      end
      m_px += m_vx;
      m_py += m_vy;
      m_vx = toward(m_vx, (r && !l) ? MAXS : (l && !r) ? -MAXS : 0);
      m_vy = toward(m_vy, (d && !u) ? MAXS : (u && !d) ? -MAXS : 0);
`ifdef SPRITE_MOTION_WRAP_EN
      if (m_px > 630 * U) m_px = (10 - 64) * U;
      else if (m_px + 64 * U < 10 * U) m_px = 630 * U;
`else
      if (m_px < 10 * U) begin m_px = 10 * U; m_vx = 0; end
      else if (m_px + 64 * U > 630 * U) begin
         m_px = (630 - 64) * U; m_vx = 0;
      end
`endif
      if (m_py < 0) begin m_py = 0; m_vy = 0; end
      else if (m_py + 32 * U > 479 * U) begin
         m_py = (479 - 32) * U; m_vy = 0;
      end
      if (h) begin
         m_stun = 1; m_vx = 0; m_vy = 0;
         m_left = (NSTUN == 0) ? 1 : NSTUN;
      end
   endtask

   task automatic check_all();
      chk("topLeftX", int'(topLeftX), m_px >>> 6);
      chk("topLeftY", int'(topLeftY), m_py >>> 6);
      chk("speedX", int'(speedX), m_vx);
      chk("speedY", int'(speedY), m_vy);
      chk("stunned", int'(stunned), int'(m_stun));
   endtask

   task automatic keys(input bit r, l, u, d);
      rightPress = r; leftPress = l; upPress = u; downPress = d;
   endtask

   task automatic frame(input bit en, input bit coll);
      @(negedge clk);
      enable = en;
      collision = coll;
      startOfFrame = 1'b1;
      model_frame(rightPress, leftPress, upPress, downPress, en, coll);
      @(negedge clk);
      startOfFrame = 1'b0;
      collision = 1'b0;
      check_all();
   endtask

   task automatic gap(input int n, input bit coll);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startOfFrame = 1'b0;
         collision = coll && (i == 0);
         if (collision) m_latch = 1;
      end
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b1;
      collision = 1'b0;
      keys(0, 0, 0, 0);
      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      resetN = 1'b1;

      // idle frames
      repeat (5) begin frame(1, 0); gap(2, 0); end

      // accelerate right
      keys(1, 0, 0, 0);
      repeat (8) begin frame(1, 0); gap(1, 0); end
      chk("t2_tlx", int'(topLeftX), 328);
      chk("t2_spx", int'(speedX), 120);

      // release, then both keys held
      keys(0, 0, 0, 0);
      repeat (8) frame(1, 0);
      chk("t3_spx", int'(speedX), 0);
      keys(1, 0, 0, 0);
      repeat (3) frame(1, 0);
      keys(1, 1, 0, 0);
      repeat (4) frame(1, 0);

      // run into the right edge, and the bottom
      keys(1, 0, 0, 1);
      repeat (140) frame(1, 0);
`ifndef SPRITE_MOTION_WRAP_EN
      chk("t4_tlx", int'(topLeftX), 566);
`endif
      chk("t4_tly", int'(topLeftY), 447);

      // collision while moving left at full speed
      keys(0, 1, 0, 0);
      repeat (10) frame(1, 0);
      gap(3, 1);
      frame(1, 0);
      chk("t5_stun", int'(stunned), 1);
      keys(1, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         gap(2, i == 5);
         frame(1, 0);
      end
      chk("t5_free", int'(stunned), 0);
      frame(1, 0);
      chk("t5_spx", int'(speedX), 20);

      // reset in the middle of a stun
      repeat (4) frame(1, 0);
      frame(1, 1);
      repeat (8) frame(1, 0);
      @(negedge clk);
      resetN = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      resetN = 1'b1;

      // frozen with a key held
      repeat (4) frame(0, 0);

      // randomized frames
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0)
            keys($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         gap($urandom_range(0, 3), $urandom_range(0, 19) == 0);
         frame($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Parametrised two-axis fixed-point motion controller for keyboard-driven sprites (player ship and similar). Per-frame acceleration and deceleration toward a capped speed on X and Y, with configurable playfield bounds. Adds a collision-triggered stun state that freezes the sprite for a set number of frames. Sits between the keyboard decoder and the sprite bitmap/draw modules, and feeds topLeftX/topLeftY to the object renderer.

Parameters:
FRAC_BITS, 6, fractional bits of position/speed (1/64 pixel)
INITIAL_X, 320, reset top-left X (pixels)
INITIAL_Y, 300, reset top-left Y (pixels)
OBJ_W, 64, sprite width (pixels)
OBJ_H, 32, sprite height (pixels)
MIN_X, 10, leftmost allowed top-left X
MAX_X, 630, rightmost allowed right edge (top-left X + OBJ_W)
MIN_Y, 0, topmost allowed top-left Y
MAX_Y, 479, lowest allowed bottom edge (top-left Y + OBJ_H)
MAX_SPEED, 120, speed cap per axis (fixed-point units per frame)
ACCEL, 20, speed change per frame (fixed-point units)
STUN_FRAMES, 15, frames frozen after a collision

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame; all motion updates occur only on this pulse
enable  in  1  0 = freeze state, speeds and position
rightPress  in  1  right key held
leftPress  in  1  left key held
upPress  in  1  up key held
downPress  in  1  down key held
collision  in  1  level, sprite pixel overlaps a hazard pixel
topLeftX  out  11 signed  pixel X = posX >>> FRAC_BITS (floor)
topLeftY  out  11 signed  pixel Y = posY >>> FRAC_BITS (floor)
speedX  out  12 signed  current X speed register
speedY  out  12 signed  current Y speed register
stunned  out  1  1 while in STUN

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset values: posX = INITIAL_X<<FRAC_BITS, posY = INITIAL_Y<<FRAC_BITS, speedX = speedY = 0, state RUN, stunned = 0, collision latch = 0, stun counter = 0.
- Collision latch: set on any clk with collision=1. Cleared on every startOfFrame after it is sampled. If collision=1 coincides with startOfFrame, it counts for that frame.
- Internal positions are 32-bit signed. The outputs are registered/derived combinationally from the registers and change only on the clk after startOfFrame.
- RUN, on startOfFrame with enable=1:
  1. pos += speed on each axis, using the old speed. This gives one frame of lag between a key press and movement.
  2. Key direction per axis: exactly one key held gives ±1. Both or neither held gives 0.
  3. Direction ±1: speed moves by ACCEL toward ±MAX_SPEED and saturates at ±MAX_SPEED. A reverse press decelerates through 0.
  4. Direction 0: speed moves toward 0 by ACCEL and never overshoots. Example: 10 becomes 0.
  5. Clamp after the update:
     - posX < MIN_X<<F: posX = MIN_X<<F, speedX = 0.
     - posX + (OBJ_W<<F) > MAX_X<<F: posX = (MAX_X-OBJ_W)<<F, speedX = 0.
     - Y is clamped the same way with MIN_Y, MAX_Y and OBJ_H.
  6. If the collision latch is set: go to STUN, speedX = speedY = 0, counter = STUN_FRAMES, stunned = 1. The position update of this frame still applies.
- STUN, on startOfFrame with enable=1:
  - Position held. Keys ignored. New collisions ignored (latch still cleared).
  - Counter decrements. When the counter reaches 0, go to RUN and set stunned = 0.
  - RUN motion resumes on the next startOfFrame, starting from speed 0.
- enable=0: state, counter, speeds and positions are held. The collision latch is still cleared on startOfFrame.
- resetN asserted mid-STUN or mid-motion: immediately returns all registers to their reset values.
- Edge cases:
  - startOfFrame held for more than one clk is treated as a separate update each cycle; the upstream VGA controller guarantees single-cycle pulses.
  - STUN_FRAMES=0: STUN lasts exactly one frame.

Optional Feature:
Macro: SPRITE_MOTION_WRAP_EN.
- Defined: the X axis wraps instead of clamping.
  - If posX > MAX_X<<F, posX = (MIN_X-OBJ_W)<<F.
  - If posX + (OBJ_W<<F) < MIN_X<<F, posX = MAX_X<<F.
  - speedX is preserved. Y still clamps.
- Undefined: X clamps as described in Behaviour; no wrap logic is synthesised.

Test Plan:
1. Reset, then idle 5 frames -> topLeftX=320, topLeftY=300, speedX=speedY=0, stunned=0 throughout.
2. rightPress held 8 frames -> speedX sequence 20,40,60,80,100,120,120,120; posX=20480+540=21020, topLeftX=328.
3. After test 2, release all keys -> speedX 100,80,60,40,20,0 then stays 0 (never negative); both left+right held gives the same decay.
4. Start topLeftX=560, hold rightPress 10 frames -> topLeftX saturates at 566 and never exceeds it, with speedX=0 on the clamp frame. With SPRITE_MOTION_WRAP_EN defined and topLeftX driven past 630 -> topLeftX becomes -54 and speedX remains 120.
5. One-clk collision pulse mid-frame while moving at speedX=120 -> at next startOfFrame stunned=1 and speedX=0; position frozen for 15 frames with rightPress held; then stunned=0, next frame speedX=20. A second collision during STUN has no effect.
6. resetN pulsed during STUN (counter=7) -> immediately stunned=0, topLeftX=320, topLeftY=300, speeds 0. enable=0 for 4 frames while rightPress held -> no change to any output.
